can_tx_frame_seq: RTL

- Transmit-side frame sequencer for the CAN controller.
- Serialises one pre-built frame, one bit per clock; clock is the bit-rate clock.
- Drives and sequences the bit-stuff generator/checker pair: enables stuffing only over SOF..CRC, inserts stuff bits on request, then emits the unstuffed tail (delimiters, ACK, EOF, intermission).
- Aborts into an error-flag sequence on a stuff error or a missing ACK.

---
 rtl/can_tx_frame_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/can_tx_frame_seq.sv
// can_tx_frame_seq: serialises one pre-built CAN frame per accept, sequencing the
// bit-stuff generator/checker and the unstuffed tail, EOF, intermission and error flags.
`default_nettype none

module can_tx_frame_seq #(
    parameter int FRAME_W       = 98,
    parameter int LEN_W         = 7,
    parameter int EOF_BITS      = 7,
    parameter int IFS_BITS      = 3,
    parameter int ERRFLAG_BITS  = 6,
    parameter int ERRDELIM_BITS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic [LEN_W-1:0]   stuff_len,
    input  logic               stuff_req,
    input  logic               stuff_error,
    input  logic               rx_bit,
    output logic               tx_bit,
    output logic               bitgen_en,
    output logic               bitchk_en,
    output logic               gen_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               ack_err
);

    localparam int TAIL_BITS = 3 + EOF_BITS;
    localparam int MAX_AB    = (TAIL_BITS > IFS_BITS) ? TAIL_BITS : IFS_BITS;
    localparam int MAX_CD    = (ERRFLAG_BITS > ERRDELIM_BITS) ? ERRFLAG_BITS : ERRDELIM_BITS;
    localparam int MAX_ALL   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W     = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] TAIL_LAST     = CNT_W'(TAIL_BITS - 1);
    localparam logic [CNT_W-1:0] IFS_LAST      = CNT_W'(IFS_BITS - 1);
    localparam logic [CNT_W-1:0] ERRFLAG_LAST  = CNT_W'(ERRFLAG_BITS - 1);
    localparam logic [CNT_W-1:0] ERRDELIM_LAST = CNT_W'(ERRDELIM_BITS - 1);
    localparam logic [CNT_W-1:0] ACK_SLOT      = CNT_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE       = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STUFFED  = 3'd1,
        S_STUFF    = 3'd2,
        S_TAIL     = 3'd3,
        S_IFS      = 3'd4,
        S_ERRFLAG  = 3'd5,
        S_ERRDELIM = 3'd6
    } state_t;

    state_t             state, state_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [LEN_W-1:0]   rem, rem_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               prev_tx;
    logic               done_n, err_n, ack_err_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            shreg   <= '0;
            rem     <= '0;
            cnt     <= '0;
            prev_tx <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            rem     <= rem_n;
            cnt     <= cnt_n;
            prev_tx <= tx_bit;
            done    <= done_n;
            err     <= err_n;
            ack_err <= ack_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        rem_n       = rem;
        cnt_n       = cnt;
        done_n      = 1'b0;
        err_n       = 1'b0;
        ack_err_n   = ack_err;
        tx_bit      = 1'b1;
        frame_ready = 1'b0;
        bitgen_en   = 1'b0;
        busy        = 1'b1;

        case (state)
            S_IDLE: begin
                busy        = 1'b0;
                frame_ready = 1'b1;
                if (frame_valid) begin
                    shreg_n   = frame_data;
                    rem_n     = (stuff_len == '0) ? LEN_ONE : stuff_len;
                    ack_err_n = 1'b0;
                    state_n   = S_STUFFED;
                end
            end
            S_STUFFED, S_STUFF: begin
                // rem counts stuffable bits still to go, including the one on the line
                tx_bit    = (state == S_STUFFED) ? shreg[FRAME_W-1] : ~prev_tx;
                bitgen_en = 1'b1;
                if (stuff_error) begin
                    state_n = S_ERRFLAG;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                end else if (stuff_req) begin
                    state_n = S_STUFF;
                end else if (rem == LEN_ONE) begin
                    state_n = S_TAIL;
                    cnt_n   = '0;
                end else begin
                    shreg_n = {shreg[FRAME_W-2:0], 1'b0};
                    rem_n   = rem - LEN_ONE;
                    state_n = S_STUFFED;
                end
            end
            S_TAIL: begin
                cnt_n = cnt + 1'b1;
                // No dominant ACK seen: the error flag starts right after the ACK slot
                if (cnt == ACK_SLOT && rx_bit) begin
                    ack_err_n = 1'b1;
                    err_n     = 1'b1;
                    state_n   = S_ERRFLAG;
                    cnt_n     = '0;
                end else if (cnt == TAIL_LAST) begin
                    done_n  = 1'b1;
                    state_n = S_IFS;
                    cnt_n   = '0;
                end
            end
            S_IFS: begin
                cnt_n = cnt + 1'b1;
                if (cnt == IFS_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            S_ERRFLAG: begin
                tx_bit = 1'b0;
                cnt_n  = cnt + 1'b1;
                if (cnt == ERRFLAG_LAST) begin
                    state_n = S_ERRDELIM;
                    cnt_n   = '0;
                end
            end
            S_ERRDELIM: begin
                cnt_n = cnt + 1'b1;
                if (cnt == ERRDELIM_LAST) begin
                    state_n = S_IFS;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bitchk_en = bitgen_en;
    assign gen_data  = tx_bit;

endmodule

`default_nettype wire
